// File: rtl/pwm_scaler_multi.sv
// Multi-channel PWM generator: a programmable prescaler ticks a shared period counter.
// Each channel has a double-buffered duty value that is applied only at period boundaries.
module pwm_scaler_multi #(
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 4
) (
  input  logic              clk_50M,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DIV_W-1:0]  div_val,
  input  logic [CNT_W-1:0]  period,
  input  logic              duty_wr,
  input  logic [CH_W-1:0]   duty_ch,
  input  logic [CNT_W-1:0]  duty_val,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              tick,
  output logic              period_end
);

  logic [DIV_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic [CNT_W-1:0]  period_act_q, period_act_d;
  logic [CNT_W-1:0]  duty_pend_q [NUM_CH];
  logic [CNT_W-1:0]  duty_pend_d [NUM_CH];
  logic [CNT_W-1:0]  duty_act_q  [NUM_CH];
  logic [CNT_W-1:0]  duty_act_d  [NUM_CH];
  logic [NUM_CH-1:0] pwm_out_q, pwm_out_d;
  logic              tick_q, tick_d;
  logic              period_end_q, period_end_d;

  logic tick_c;
  logic wrap_c;
  logic load_c;

  // The >= test also recovers when div_val drops below the running count.
  assign tick_c = (pre_cnt_q >= div_val);
  assign wrap_c = tick_c && (pwm_cnt_q == period_act_q);

  // Prescaler and period counter; both held at zero while disabled.
  always_comb begin
    pre_cnt_d    = pre_cnt_q;
    pwm_cnt_d    = pwm_cnt_q;
    tick_d       = 1'b0;
    period_end_d = 1'b0;
    load_c       = 1'b0;
    if (!en) begin
      pre_cnt_d = '0;
      pwm_cnt_d = '0;
      load_c    = 1'b1;
    end else begin
      if (tick_c) begin
        pre_cnt_d = '0;
        tick_d    = 1'b1;
        if (wrap_c) begin
          pwm_cnt_d    = '0;
          period_end_d = 1'b1;
          load_c       = 1'b1;
        end else begin
          pwm_cnt_d = pwm_cnt_q + CNT_W'(1);
        end
      end else begin
        pre_cnt_d = pre_cnt_q + DIV_W'(1);
      end
    end
  end

  // Shadow registers; loading from the post-write pending value gives write-through.
  always_comb begin
    period_act_d = load_c ? period : period_act_q;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      duty_pend_d[i] = duty_pend_q[i];
      if (duty_wr && (duty_ch == CH_W'(i))) begin
        duty_pend_d[i] = duty_val;
      end
      duty_act_d[i] = load_c ? duty_pend_d[i] : duty_act_q[i];
    end
  end

  // Output compare against the current counter, registered.
  always_comb begin
    pwm_out_d = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      pwm_out_d[i] = en & (pwm_cnt_q < duty_act_q[i]);
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q    <= '0;
      pwm_cnt_q    <= '0;
      period_act_q <= '0;
      pwm_out_q    <= '0;
      tick_q       <= 1'b0;
      period_end_q <= 1'b0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        duty_pend_q[i] <= '0;
        duty_act_q[i]  <= '0;
      end
    end else begin
      pre_cnt_q    <= pre_cnt_d;
      pwm_cnt_q    <= pwm_cnt_d;
      period_act_q <= period_act_d;
      pwm_out_q    <= pwm_out_d;
      tick_q       <= tick_d;
      period_end_q <= period_end_d;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        duty_pend_q[i] <= duty_pend_d[i];
        duty_act_q[i]  <= duty_act_d[i];
      end
    end
  end

  assign pwm_out    = pwm_out_q;
  assign tick       = tick_q;
  assign period_end = period_end_q;

endmodule

// File: tb/tb_pwm_scaler_multi.sv
// Directed bench for pwm_scaler_multi: captures per-cycle outputs into arrays
// and compares pulse counts and individual cycles against hand-derived values.
module tb_pwm_scaler_multi;

  localparam int unsigned DIV_W  = 16;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = 4;

  logic              clk_50M = 1'b0;
  logic              rst_n;
  logic              en;
  logic [DIV_W-1:0]  div_val;
  logic [CNT_W-1:0]  period;
  logic              duty_wr;
  logic [CH_W-1:0]   duty_ch;
  logic [CNT_W-1:0]  duty_val;
  logic [NUM_CH-1:0] pwm_out;
  logic              tick;
  logic              period_end;

  int errors = 0;
  int checks = 0;

  logic [NUM_CH-1:0] c_out  [256];
  logic              c_tick [256];
  logic              c_pe   [256];

  pwm_scaler_multi #(
    .DIV_W (DIV_W),
    .CNT_W (CNT_W),
    .NUM_CH(NUM_CH),
    .CH_W  (CH_W)
  ) dut (
    .clk_50M   (clk_50M),
    .rst_n     (rst_n),
    .en        (en),
    .div_val   (div_val),
    .period    (period),
    .duty_wr   (duty_wr),
    .duty_ch   (duty_ch),
    .duty_val  (duty_val),
    .pwm_out   (pwm_out),
    .tick      (tick),
    .period_end(period_end)
  );

  always #10 clk_50M = ~clk_50M;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic wr_duty(input int ch, input int val);
    duty_wr  = 1'b1;
    duty_ch  = CH_W'(ch);
    duty_val = CNT_W'(val);
    step();
    duty_wr  = 1'b0;
  endtask

  // Disabled for two cycles: counters cleared, shadows loaded.
  task automatic setup(input int dv, input int per);
    en      = 1'b0;
    div_val = DIV_W'(dv);
    period  = CNT_W'(per);
    step();
    step();
  endtask

  // Entry k holds the outputs right after edge k; inputs for edge k are set beforehand.
  task automatic capture(input int n, input int wk0, input int wc0, input int wv0,
                         input int wk1, input int wc1, input int wv1,
                         input int elo, input int ehi);
    for (int k = 0; k < n; k++) begin
      en       = (k >= elo && k < ehi) ? 1'b0 : 1'b1;
      duty_wr  = (k == wk0) || (k == wk1);
      duty_ch  = (k == wk1) ? CH_W'(wc1) : CH_W'(wc0);
      duty_val = (k == wk1) ? CNT_W'(wv1) : CNT_W'(wv0);
      step();
      c_out[k]  = pwm_out;
      c_tick[k] = tick;
      c_pe[k]   = period_end;
    end
    duty_wr = 1'b0;
  endtask

  function automatic int hi_cnt(input int ch, input int lo, input int hi);
    int n = 0;
    for (int k = lo; k < hi; k++) if (c_out[k][ch]) n++;
    return n;
  endfunction

  function automatic int pe_cnt(input int lo, input int hi);
    int n = 0;
    for (int k = lo; k < hi; k++) if (c_pe[k]) n++;
    return n;
  endfunction

  function automatic int tick_cnt(input int lo, input int hi);
    int n = 0;
    for (int k = lo; k < hi; k++) if (c_tick[k]) n++;
    return n;
  endfunction

  function automatic int first_tick(input int n);
    for (int k = 0; k < n; k++) if (c_tick[k]) return k;
    return -1;
  endfunction

  initial begin
    rst_n = 1'b0; en = 1'b0; div_val = '0; period = '0;
    duty_wr = 1'b0; duty_ch = '0; duty_val = '0;
    step(); step(); step();
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_pe", int'(period_end), 0);
    rst_n = 1'b1;
    step();

    // Legacy divide-by-16: 8 high / 8 low, tick every cycle.
    wr_duty(0, 8);
    setup(0, 15);
    capture(32, -1, 0, 0, -1, 0, 0, -1, -1);
    chk("t1_ch0_high", hi_cnt(0, 0, 32), 16);
    chk("t1_ch0_k7", int'(c_out[7][0]), 1);
    chk("t1_ch0_k8", int'(c_out[8][0]), 0);
    chk("t1_ch1_low", hi_cnt(1, 0, 32), 0);
    chk("t1_ticks", tick_cnt(0, 32), 32);
    chk("t1_pe_cnt", pe_cnt(0, 32), 2);
    chk("t1_pe_k15", int'(c_pe[15]), 1);

    // Prescale by 5, period 10 ticks: ch1 high 15 of 50 cycles.
    wr_duty(1, 3);
    setup(4, 9);
    capture(100, -1, 0, 0, -1, 0, 0, -1, -1);
    chk("t2_first_tick", first_tick(100), 4);
    chk("t2_ticks", tick_cnt(0, 100), 20);
    chk("t2_ch1_high", hi_cnt(1, 0, 100), 30);
    chk("t2_ch1_k14", int'(c_out[14][1]), 1);
    chk("t2_ch1_k15", int'(c_out[15][1]), 0);
    chk("t2_ch1_k50", int'(c_out[50][1]), 1);
    chk("t2_ch0_high", hi_cnt(0, 0, 100), 80);
    chk("t2_pe_cnt", pe_cnt(0, 100), 2);
    chk("t2_pe_k49", int'(c_pe[49]), 1);

    // Extremes: duty 0 never high, duty above period always high.
    wr_duty(0, 0);
    wr_duty(1, 10);
    wr_duty(2, 255);
    setup(0, 9);
    capture(40, -1, 0, 0, -1, 0, 0, -1, -1);
    chk("t3_ch0_zero", hi_cnt(0, 0, 40), 0);
    chk("t3_ch1_full", hi_cnt(1, 0, 40), 40);
    chk("t3_ch2_full", hi_cnt(2, 0, 40), 40);
    chk("t3_pe_cnt", pe_cnt(0, 40), 4);

    // Shadow update mid-period (4->7), then write-through at a boundary (7->2).
    wr_duty(0, 4);
    setup(0, 9);
    capture(50, 12, 0, 7, 29, 0, 2, -1, -1);
    chk("t4_p0_high", hi_cnt(0, 0, 10), 4);
    chk("t4_p1_high", hi_cnt(0, 10, 20), 4);
    chk("t4_k13", int'(c_out[13][0]), 1);
    chk("t4_k14", int'(c_out[14][0]), 0);
    chk("t4_p2_high", hi_cnt(0, 20, 30), 7);
    chk("t4_k26", int'(c_out[26][0]), 1);
    chk("t4_k27", int'(c_out[27][0]), 0);
    chk("t4_wt_p3_high", hi_cnt(0, 30, 40), 2);
    chk("t4_wt_p4_high", hi_cnt(0, 40, 50), 2);

    // Illegal channel writes ignored; en dropped mid-high, then restart at zero.
    setup(0, 9);
    capture(40, 5, 4, 9, 6, 15, 9, 21, 24);
    chk("t5_ch0_high", hi_cnt(0, 10, 20), 2);
    chk("t5_ch1_high", hi_cnt(1, 10, 20), 10);
    chk("t5_ch3_high", hi_cnt(3, 10, 20), 0);
    chk("t5_k20_ch0", int'(c_out[20][0]), 1);
    chk("t5_dis_ch0", int'(c_out[21][0]), 0);
    chk("t5_dis_ch1", int'(c_out[21][1]), 0);
    chk("t5_dis_tick", tick_cnt(21, 24), 0);
    chk("t5_dis_pe", pe_cnt(21, 24), 0);
    chk("t5_re_k25", int'(c_out[25][0]), 1);
    chk("t5_re_k26", int'(c_out[26][0]), 0);
    chk("t5_re_pe33", int'(c_pe[33]), 1);
    chk("t5_re_pe_cnt", pe_cnt(24, 40), 1);

    // Async reset mid-high pulse, then no memory of previous duties.
    setup(0, 9);
    capture(1, -1, 0, 0, -1, 0, 0, -1, -1);
    chk("t6_pre_rst", int'(c_out[0]), 7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_pwm", int'(pwm_out), 0);
    chk("t6_async_tick", int'(tick), 0);
    step();
    step();
    rst_n = 1'b1;
    capture(30, -1, 0, 0, -1, 0, 0, -1, -1);
    chk("t6_post_ch0", hi_cnt(0, 0, 30), 0);
    chk("t6_post_ch1", hi_cnt(1, 0, 30), 0);
    chk("t6_post_ch2", hi_cnt(2, 0, 30), 0);
    chk("t6_post_pe", pe_cnt(0, 30), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
